umips_uart_rx: RTL and testbench

UMIPS_UART_RX -- requirements
Module: umips_uart_rx

---
 rtl/umips_uart_rx_if.sv | 11 +
 rtl/umips_uart_rx.sv | 122 ++++++++++++
 tb/tb_umips_uart_rx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/umips_uart_rx_if.sv
// rtl/umips_uart_rx_if.sv - serial line and MMIO read port of the UART receiver
interface umips_uart_rx_if;
  logic        rx;
  logic        re;
  logic [31:0] a0;
  logic [31:0] rd0;
  logic        irq;

  modport master (output rx, output re, output a0, input rd0, input irq);
  modport slave  (input rx, input re, input a0, output rd0, output irq);
endinterface

// File: rtl/umips_uart_rx.sv
// rtl/umips_uart_rx.sv - 8N1 UART receiver with receive FIFO and MMIO DATA/STATUS read port
module umips_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input logic           clk,
  input logic           rst,
  umips_uart_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            sync0, sync1;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     count, count_next;
  logic            frame_err, overrun, irq_q;
  logic            expire, push_req, frame_set, empty, full, pop, push_ok, stat_rd;
  logic [7:0]      count8;
  logic            unused_a0;

  assign unused_a0 = ^{bus.a0[31:3], bus.a0[1:0]};

  assign expire    = (cnt <= CW'(1));
  assign push_req  = (state == STOP) && expire && sync1;
  assign frame_set = (state == STOP) && expire && !sync1;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign pop       = bus.re && !bus.a0[2] && !empty;
  assign stat_rd   = bus.re && bus.a0[2];
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok   = push_req && (!full || pop);
  assign count8    = 8'(count);

  always_comb begin
    count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0   <= 1'b1;
      sync1   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync0 <= bus.rx;
      sync1 <= sync0;
      case (state)
        IDLE: begin
          if (!sync1) begin
            state <= START;
            cnt   <= HALF_BIT;
          end
        end
        START: begin
          if (expire) begin
            bit_idx <= '0;
            cnt     <= FULL_BIT;
            state   <= sync1 ? IDLE : DATA;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (expire) begin
            shreg   <= {sync1, shreg[7:1]};
            cnt     <= FULL_BIT;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (expire) state <= IDLE;
          else        cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp + AW'(1);
      count <= count_next;
      irq_q <= (count_next != '0);
      // Setting a flag takes priority over a STATUS-read clear in the same cycle.
      if (frame_set)                   frame_err <= 1'b1;
      else if (stat_rd)                frame_err <= 1'b0;
      if (push_req && full && !pop)    overrun   <= 1'b1;
      else if (stat_rd)                overrun   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= shreg;
  end

  assign bus.irq = irq_q;
  assign bus.rd0 = bus.a0[2] ? {16'b0, count8, 4'b0, frame_err, overrun, full, !empty}
                             : (empty ? 32'b0 : {24'b0, mem[rp]});
endmodule

// File: tb/tb_umips_uart_rx.sv
// tb/tb_umips_uart_rx.sv - self-checking bench for umips_uart_rx against a queue-based model
module tb_umips_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  umips_uart_rx_if bus ();

  umips_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mq[$];
  bit         m_fe, m_ov;
  bit         check_en = 1'b0;

  function automatic logic [31:0] model_status();
    logic [7:0] c;
    c = 8'(mq.size());
    return {16'b0, c, 4'b0, m_fe, m_ov, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a[2]) return model_status();
    if (mq.size() == 0) return 32'h0;
    return {24'b0, mq[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("irq_cycle", {31'b0, bus.irq}, {31'b0, mq.size() != 0});
      check("rd0_cycle", bus.rd0, model_rd(bus.a0));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; optionally a DATA read lands exactly on the stop-bit sample cycle.
  task automatic send(input logic [7:0] b, input bit stop_ok, input bit pop_at_stop);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    check_en = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10 * CPB; i++) begin
      bus.rx = bits[i / CPB];
      if (pop_at_stop && i == 9 * CPB + 10) begin
        bus.a0 = 32'h0;
        bus.re = 1'b1;
      end
      if (pop_at_stop && i == 9 * CPB + 11) bus.re = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.rx = 1'b1;
    if (pop_at_stop && mq.size() != 0) void'(mq.pop_front());
    if (!stop_ok)                 m_fe = 1'b1;
    else if (mq.size() < DEPTH)   mq.push_back(b);
    else                          m_ov = 1'b1;
    check_en = 1'b1;
    idle(24);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk);
    #1;
    bus.a0 = addr;
    bus.re = 1'b1;
    @(negedge clk);
    data = bus.rd0;
    @(posedge clk);
    #1;
    bus.re = 1'b0;
    if (addr[2]) begin
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
    end
  endtask

  task automatic expect_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    rd(addr, d);
    check(name, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    bus.rx = 1'b1;
    bus.re = 1'b0;
    bus.a0 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_irq", {31'b0, bus.irq}, 32'h0);
    #1 rst = 1'b0;
    check_en = 1'b1;
    idle(4);
    expect_rd("reset_status", 32'h4, 32'h0);

    // Single byte receive, plus re=0 peeks that must not pop.
    send(8'hA5, 1'b1, 1'b0);
    check("rx_irq", {31'b0, bus.irq}, 32'h1);
    bus.a0 = 32'h0;
    idle(5);
    bus.a0 = 32'h4;
    idle(5);
    expect_rd("rx_status", 32'h4, 32'h0000_0101);
    expect_rd("rx_data", 32'h0, 32'h0000_00A5);
    expect_rd("rx_status_after", 32'h4, 32'h0);

    // Short low pulse on the line.
    check_en = 1'b0;
    @(posedge clk);
    #1 bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    check_en = 1'b1;
    idle(40);
    expect_rd("glitch_status", 32'h4, 32'h0);

    // Stop bit low.
    send(8'h3C, 1'b0, 1'b0);
    expect_rd("ferr_status", 32'h4, 32'h0000_0008);
    expect_rd("ferr_status2", 32'h4, 32'h0);

    // Overflow and pointer wrap.
    for (int k = 1; k <= 9; k++) send(8'(k), 1'b1, 1'b0);
    expect_rd("ovf_status", 32'h4, 32'h0000_0807);
    for (int k = 1; k <= 8; k++) expect_rd("ovf_data", 32'h0, 32'(k));
    expect_rd("ovf_empty_data", 32'h0, 32'h0);
    expect_rd("ovf_status2", 32'h4, 32'h0);

    // Push and pop on the same edge with the FIFO full.
    for (int k = 0; k < 8; k++) send(8'h10 + 8'(k), 1'b1, 1'b0);
    send(8'h18, 1'b1, 1'b1);
    expect_rd("pp_status", 32'h4, 32'h0000_0803);
    for (int k = 1; k <= 8; k++) expect_rd("pp_data", 32'h0, 32'h10 + 32'(k));
    expect_rd("pp_status2", 32'h4, 32'h0);

    // Reset in the middle of data bit 3, then a clean frame.
    check_en = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4 * CPB + CPB / 2; i++) begin
      bus.rx = 1'b0;
      @(posedge clk);
      #1;
    end
    rst    = 1'b1;
    bus.rx = 1'b1;
    idle(3);
    rst = 1'b0;
    mq.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    check_en = 1'b1;
    idle(40);
    expect_rd("mid_rst_status", 32'h4, 32'h0);
    send(8'h5A, 1'b1, 1'b0);
    expect_rd("mid_rst_status2", 32'h4, 32'h0000_0101);
    expect_rd("mid_rst_data", 32'h0, 32'h0000_005A);
    expect_rd("mid_rst_status3", 32'h4, 32'h0);
    idle(4);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
